// File: rtl/fft16_pkg.sv
// fft16_pkg: shared constants and bank state type for the radix-4 commutator controller
package fft16_pkg;
   localparam int LANES  = 4;
   localparam int SLOT_W = 2;
   localparam int STAT_W = 8;
   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_state_e;
endpackage

// File: rtl/fft16_commut_ctrl_if.sv
// fft16_commut_ctrl_if: write/read handshake and slot/bank select bundle of the commutator controller
// Optional FFT_CTRL_STATS_EN adds the statistics counters.
interface fft16_commut_ctrl_if #(
   parameter int SLOT_W = 2
`ifdef FFT_CTRL_STATS_EN
   , parameter int STAT_W = 8
`endif
);
   logic              in_valid, in_ready, wr_en, wr_bank;
   logic [SLOT_W-1:0] wr_slot;
   logic              out_valid, out_ready, rd_bank, out_last;
   logic [SLOT_W-1:0] rd_slot;
`ifdef FFT_CTRL_STATS_EN
   logic [STAT_W-1:0] stat_frames_in, stat_frames_out, stat_stalls;
   modport slave (input in_valid, out_ready,
                  output in_ready, wr_en, wr_bank, wr_slot, out_valid, rd_bank, rd_slot, out_last,
                  output stat_frames_in, stat_frames_out, stat_stalls);
   modport master (output in_valid, out_ready,
                   input in_ready, wr_en, wr_bank, wr_slot, out_valid, rd_bank, rd_slot, out_last,
                   input stat_frames_in, stat_frames_out, stat_stalls);
`else
   modport slave (input in_valid, out_ready,
                  output in_ready, wr_en, wr_bank, wr_slot, out_valid, rd_bank, rd_slot, out_last);
   modport master (output in_valid, out_ready,
                   input in_ready, wr_en, wr_bank, wr_slot, out_valid, rd_bank, rd_slot, out_last);
`endif
endinterface

// File: rtl/fft16_bank_tracker.sv
// fft16_bank_tracker: per-bank EMPTY/FILLING/FULL/DRAINING state machine
module fft16_bank_tracker
   import fft16_pkg::*;
(
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clr,
   input  logic        i_wr_hit,
   input  logic        i_wr_last,
   input  logic        i_rd_hit,
   input  logic        i_rd_last,
   output bank_state_e o_state
);
   // write and read never target the same bank in one cycle: their state sets are disjoint
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) o_state <= EMPTY;
      else if (i_clr) o_state <= EMPTY;
      else if (i_wr_hit) o_state <= i_wr_last ? FULL : FILLING;
      else if (i_rd_hit) o_state <= i_rd_last ? EMPTY : DRAINING;
endmodule

// File: rtl/fft16_commut_ctrl.sv
// fft16_commut_ctrl: ping-pong bank sequencer for the 16-point radix-4 4x4 transpose.
// Optional FFT_CTRL_STATS_EN adds saturating frame/stall counters.
module fft16_commut_ctrl #(
   parameter int LANES  = fft16_pkg::LANES,
   parameter int SLOT_W = fft16_pkg::SLOT_W
`ifdef FFT_CTRL_STATS_EN
   , parameter int STAT_W = fft16_pkg::STAT_W
`endif
) (
   input logic                i_clk,
   input logic                i_reset,
   input logic                i_flush,
   fft16_commut_ctrl_if.slave bus
);
   import fft16_pkg::*;
   if (LANES != 4 || SLOT_W != 2) begin : g_cfg_chk
      $error("fft16_commut_ctrl: radix-4 requires LANES=4, SLOT_W=2");
   end
   bank_state_e       w_state [2];
   logic              r_wr_bank, r_rd_bank;
   logic [SLOT_W-1:0] r_wr_slot, r_rd_slot;
   logic              w_in_ready, w_wr_en, w_wr_last, w_out_valid, w_rd_fire, w_rd_last;
   assign w_in_ready  = w_state[r_wr_bank] inside {EMPTY, FILLING};
   assign w_out_valid = w_state[r_rd_bank] inside {FULL, DRAINING};
   assign w_wr_en     = bus.in_valid && w_in_ready && !i_flush;
   assign w_rd_fire   = w_out_valid && bus.out_ready && !i_flush;
   assign w_wr_last   = &r_wr_slot;
   assign w_rd_last   = &r_rd_slot;
   for (genvar b = 0; b < 2; b++) begin : g_bank
      fft16_bank_tracker u_trk (
         .i_clk     (i_clk),
         .i_rst     (i_reset),
         .i_clr     (i_flush),
         .i_wr_hit  (w_wr_en && r_wr_bank == 1'(b)),
         .i_wr_last (w_wr_last),
         .i_rd_hit  (w_rd_fire && r_rd_bank == 1'(b)),
         .i_rd_last (w_rd_last),
         .o_state   (w_state[b])
      );
   end
   // slot counters wrap naturally at SLOT_W bits; the bank flips on the wrap
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset || i_flush) begin
         r_wr_bank <= 1'b0;
         r_wr_slot <= '0;
         r_rd_bank <= 1'b0;
         r_rd_slot <= '0;
      end else begin
         if (w_wr_en) begin
            r_wr_slot <= r_wr_slot + 1'b1;
            if (w_wr_last) r_wr_bank <= ~r_wr_bank;
         end
         if (w_rd_fire) begin
            r_rd_slot <= r_rd_slot + 1'b1;
            if (w_rd_last) r_rd_bank <= ~r_rd_bank;
         end
      end
   assign bus.in_ready  = w_in_ready;
   assign bus.wr_en     = w_wr_en;
   assign bus.wr_bank   = r_wr_bank;
   assign bus.wr_slot   = r_wr_slot;
   assign bus.out_valid = w_out_valid;
   assign bus.rd_bank   = r_rd_bank;
   assign bus.rd_slot   = r_rd_slot;
   assign bus.out_last  = w_out_valid && w_rd_last;
`ifdef FFT_CTRL_STATS_EN
   logic [STAT_W-1:0] r_frames_in, r_frames_out, r_stalls;
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset || i_flush) begin
         r_frames_in  <= '0;
         r_frames_out <= '0;
         r_stalls     <= '0;
      end else begin
         if (w_wr_en && w_wr_last && !(&r_frames_in)) r_frames_in <= r_frames_in + 1'b1;
         if (w_rd_fire && w_rd_last && !(&r_frames_out)) r_frames_out <= r_frames_out + 1'b1;
         if (bus.in_valid && !w_in_ready && !(&r_stalls)) r_stalls <= r_stalls + 1'b1;
      end
   assign bus.stat_frames_in  = r_frames_in;
   assign bus.stat_frames_out = r_frames_out;
   assign bus.stat_stalls     = r_stalls;
`endif
endmodule

// File: tb/tb_fft16_commut_ctrl.sv
// tb_fft16_commut_ctrl: scenario tasks plus a write-pointer model and transposed-read scoreboard
module tb_fft16_commut_ctrl;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;

   fft16_commut_ctrl_if bus ();
   fft16_commut_ctrl dut (.i_clk(clk), .i_reset(rst), .i_flush(flush), .bus(bus));

   typedef struct packed {logic bank; logic [1:0] slot; logic last;} exp_t;
   exp_t q[$];
   int   m_cnt = 0;

   // every accepted write is checked against the model; a slot-3 write queues the frame's 4 reads
   always @(negedge clk) begin
      if (rst || flush) begin
         q.delete();
         m_cnt = 0;
      end else begin
         if (bus.wr_en) begin
            n_chk++;
            if (bus.wr_bank !== m_cnt[2] || bus.wr_slot !== m_cnt[1:0]) begin
               n_fail++;
               $display("FAIL wr_ptr: got bank %0d slot %0d, expected bank %0d slot %0d",
                        bus.wr_bank, bus.wr_slot, m_cnt[2], m_cnt[1:0]);
            end
            if (m_cnt[1:0] == 2'd3)
               for (int s = 0; s < 4; s++) q.push_back('{m_cnt[2], 2'(s), s == 3});
            m_cnt++;
         end
         if (bus.out_valid && bus.out_ready) begin
            n_chk++;
            if (q.size() == 0) begin
               n_fail++;
               $display("FAIL rd_beat: unexpected beat bank %0d slot %0d", bus.rd_bank, bus.rd_slot);
            end else begin
               exp_t e;
               e = q.pop_front();
               if ({bus.rd_bank, bus.rd_slot, bus.out_last} !== e) begin
                  n_fail++;
                  $display("FAIL rd_beat: got bank/slot/last %b, expected %b",
                           {bus.rd_bank, bus.rd_slot, bus.out_last}, e);
               end
            end
         end
      end
   end

   task automatic cyc(input logic iv, input logic ordy, input logic fl);
      @(posedge clk);
      #1;
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      flush         = fl;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_chk++;
      if ({bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_slot, bus.out_valid, bus.rd_bank, bus.rd_slot, bus.out_last}
          !== 10'b10_0000_0000) begin
         n_fail++;
         $display("FAIL reset: got rdy/wen/wb/ws/ov/rb/rs/last %b, expected 1000000000",
                  {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_slot, bus.out_valid, bus.rd_bank, bus.rd_slot, bus.out_last});
      end
`ifdef FFT_CTRL_STATS_EN
      n_chk++;
      if ({bus.stat_frames_in, bus.stat_frames_out, bus.stat_stalls} !== 24'd0) begin
         n_fail++;
         $display("FAIL reset_stats: got %h, expected 0", {bus.stat_frames_in, bus.stat_frames_out, bus.stat_stalls});
      end
`endif
   endtask

   task automatic test_single();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         cyc(c < 4, 1'b1, 1'b0);
         n_chk++;
         if (c < 4) begin
            if ({bus.wr_en, bus.wr_bank, bus.wr_slot, bus.out_valid} !== {1'b1, 1'b0, 2'(c), 1'b0}) begin
               n_fail++;
               $display("FAIL single_wr c=%0d: got wen/wb/ws/ov %b, expected %b", c,
                        {bus.wr_en, bus.wr_bank, bus.wr_slot, bus.out_valid}, {1'b1, 1'b0, 2'(c), 1'b0});
            end
         end else if ({bus.out_valid, bus.rd_bank, bus.rd_slot, bus.out_last} !== {c < 8, c == 8, 2'(c - 4), c == 7}) begin
            n_fail++;
            $display("FAIL single_rd c=%0d: got ov/rb/rs/last %b, expected %b", c,
                     {bus.out_valid, bus.rd_bank, bus.rd_slot, bus.out_last}, {c < 8, c == 8, 2'(c - 4), c == 7});
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int c = 0; c < 17; c++) begin
         cyc(c < 12, 1'b1, 1'b0);
         if (c < 12) begin
            n_chk++;
            if ({bus.in_ready, bus.wr_bank} !== {1'b1, 1'((c / 4) % 2)}) begin
               n_fail++;
               $display("FAIL stream_in c=%0d: got rdy/bank %b, expected %b", c,
                        {bus.in_ready, bus.wr_bank}, {1'b1, 1'((c / 4) % 2)});
            end
         end
         if (c >= 4) begin
            n_chk++;
            if (bus.out_valid !== (c < 16)) begin
               n_fail++;
               $display("FAIL stream_out c=%0d: got out_valid %b, expected %b", c, bus.out_valid, c < 16);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int c = 0; c < 19; c++) begin
         cyc(c < 14, c >= 9, 1'b0);
         n_chk++;
         if (c < 8 && bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_accept c=%0d: got in_ready %b, expected 1", c, bus.in_ready);
         end
         if (c >= 8 && c <= 12 && {bus.in_ready, bus.wr_en} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_block c=%0d: got rdy/wen %b, expected 00", c, {bus.in_ready, bus.wr_en});
         end
         if (c >= 9 && c <= 12 && {bus.out_valid, bus.rd_bank, bus.rd_slot, bus.out_last} !== {1'b1, 1'b0, 2'(c - 9), c == 12}) begin
            n_fail++;
            $display("FAIL bp_drain c=%0d: got ov/rb/rs/last %b, expected %b", c,
                     {bus.out_valid, bus.rd_bank, bus.rd_slot, bus.out_last}, {1'b1, 1'b0, 2'(c - 9), c == 12});
         end
         if (c == 13 && {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_slot} !== 5'b11000) begin
            n_fail++;
            $display("FAIL bp_reopen: got rdy/wen/wb/ws %b, expected 11000", {bus.in_ready, bus.wr_en, bus.wr_bank, bus.wr_slot});
         end
`ifdef FFT_CTRL_STATS_EN
         if (c == 13) begin
            n_chk++;
            if ({bus.stat_frames_in, bus.stat_frames_out, bus.stat_stalls} !== {8'd2, 8'd1, 8'd5}) begin
               n_fail++;
               $display("FAIL bp_stats: got in/out/stalls %0d/%0d/%0d, expected 2/1/5",
                        bus.stat_frames_in, bus.stat_frames_out, bus.stat_stalls);
            end
         end
`endif
      end
   endtask

   task automatic test_hold();
      do_reset();
      for (int c = 0; c < 14; c++) begin
         cyc(c < 4, c < 6 || c > 10, 1'b0);
         if (c >= 6 && c <= 10) begin
            n_chk++;
            if ({bus.out_valid, bus.rd_bank, bus.rd_slot} !== 4'b1010) begin
               n_fail++;
               $display("FAIL hold c=%0d: got ov/rb/rs %b, expected 1010", c, {bus.out_valid, bus.rd_bank, bus.rd_slot});
            end
         end
         if (c == 12 || c == 13) begin
            n_chk++;
            if ({bus.out_valid, bus.rd_slot, bus.out_last} !== (c == 12 ? 4'b1111 : 4'b0000)) begin
               n_fail++;
               $display("FAIL hold_release c=%0d: got ov/rs/last %b", c, {bus.out_valid, bus.rd_slot, bus.out_last});
            end
         end
      end
   endtask

   task automatic test_flush();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         cyc(c < 4, 1'b1, c == 2);
         if (c == 2) begin
            n_chk++;
            if (bus.wr_en !== 1'b0) begin
               n_fail++;
               $display("FAIL flush_wen: got wr_en %b, expected 0", bus.wr_en);
            end
         end
         if (c == 3) begin
            n_chk++;
            if ({bus.wr_en, bus.wr_bank, bus.wr_slot} !== 4'b1000) begin
               n_fail++;
               $display("FAIL flush_restart: got wen/wb/ws %b, expected 1000", {bus.wr_en, bus.wr_bank, bus.wr_slot});
            end
         end
         if (c >= 4) begin
            n_chk++;
            if (bus.out_valid !== 1'b0) begin
               n_fail++;
               $display("FAIL flush_nout c=%0d: got out_valid %b, expected 0", c, bus.out_valid);
            end
         end
      end
   endtask

`ifdef FFT_CTRL_STATS_EN
   task automatic test_saturate();
      do_reset();
      for (int c = 0; c < 1200; c++) cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      n_chk++;
      if ({bus.stat_frames_in, bus.stat_frames_out, bus.stat_stalls} !== {8'd255, 8'd255, 8'd0}) begin
         n_fail++;
         $display("FAIL saturate: got in/out/stalls %0d/%0d/%0d, expected 255/255/0",
                  bus.stat_frames_in, bus.stat_frames_out, bus.stat_stalls);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_hold();
      test_flush();
`ifdef FFT_CTRL_STATS_EN
      test_saturate();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
